// File: rtl/clk_tick_divider.sv
// Programmable tick/clock divider with a shadowed divisor applied at period boundaries.
// Define CLK_TICK_DIVIDER_BUFG_EN to route clk_out through a BUFG global buffer.
module clk_tick_divider #(
  parameter int CNT_W       = 26,
  parameter int DIV_DEFAULT = 50_000_000
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             load_busy,
  output logic             tick_out,
  output logic             clk_out,
  output logic [CNT_W-1:0] count_out
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);
  localparam logic [CNT_W-1:0] ZERO    = '0;

  // Divisors below 2 cannot form a period, so they are raised to 2 on capture.
  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] v);
    return (v < TWO) ? TWO : v;
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] shd_q, shd_d;
  logic             clk_q, clk_d;
  logic             busy_q, busy_d;

  logic [CNT_W-1:0] last_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic [CNT_W-1:0] load_val_s;
  logic             wrap_s;

  assign last_s     = div_q - ONE;
  assign cnt_inc_s  = cnt_q + ONE;
  assign load_val_s = clamp_div(div_val);
  // >= also catches a count left beyond the end by a shrinking divisor.
  assign wrap_s     = (cnt_q >= last_s);

  // Next-state selection for counter, divided clock and divisor registers.
  always_comb begin
    cnt_d  = cnt_q;
    clk_d  = clk_q;
    div_d  = div_q;
    shd_d  = shd_q;
    busy_d = busy_q;
    if (!en) begin
      if (div_load) begin
        div_d  = load_val_s;
        shd_d  = load_val_s;
        cnt_d  = ZERO;
        clk_d  = 1'b0;
        busy_d = 1'b0;
      end else begin
        busy_d = busy_q;
      end
    end else if (wrap_s) begin
      cnt_d  = ZERO;
      clk_d  = 1'b0;
      busy_d = 1'b0;
      if (div_load) begin
        div_d = load_val_s;
        shd_d = load_val_s;
      end else if (busy_q) begin
        div_d = shd_q;
      end else begin
        div_d = div_q;
      end
    end else begin
      cnt_d = cnt_inc_s;
      clk_d = (cnt_inc_s >= (div_q >> 1));
      if (div_load) begin
        shd_d  = load_val_s;
        busy_d = 1'b1;
      end else begin
        busy_d = busy_q;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      cnt_q  <= ZERO;
      clk_q  <= 1'b0;
      div_q  <= DIV_RST;
      shd_q  <= DIV_RST;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      clk_q  <= clk_d;
      div_q  <= div_d;
      shd_q  <= shd_d;
      busy_q <= busy_d;
    end
  end

  // Tick is qualified by the live enable, so it cannot be a registered copy.
  assign tick_out  = en & (cnt_q == last_s);
  assign load_busy = busy_q;
  assign count_out = cnt_q;

`ifdef CLK_TICK_DIVIDER_BUFG_EN
  BUFG u_clk_out_bufg (
    .I (clk_q),
    .O (clk_out)
  );
`else
  assign clk_out = clk_q;
`endif

endmodule
